seg_disp: RTL and testbench

SEG_DISP -- requirements
Module: seg_disp

---
 rtl/seg_disp_if.sv | 16 +
 rtl/seg_disp.sv | 68 ++++++
 tb/tb_seg_disp.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seg_disp_if.sv
// seg_disp_if -- digit/segment bundle for the seven-segment decoder.
//
// Signals:
//   s    [3:0]  hex digit to display, 0x0-0xF
//   seg  [6:0]  segment drives {g,f,e,d,c,b,a}, active-low (0 = lit)
//
// Modports:
//   master  drives s, observes seg (digit source / testbench)
//   slave   observes s, drives seg (the decoder)
interface seg_disp_if;
    logic [3:0] s;
    logic [6:0] seg;

    modport master (output s, input seg);
    modport slave  (input s, output seg);
endinterface

// File: rtl/seg_disp.sv
// seg_disp -- hex digit to seven-segment decoder, active-low segments.
//
// Ports:
//   clk    input   system clock, rising edge active
//   reset  input   synchronous active-low reset
//   bus    slave   seg_disp_if: s (hex digit in), seg ({g,f,e,d,c,b,a} out, 0 = lit)
//
// Configuration:
//   SEG_DISP_REG_OUT_EN  undefined (default): seg is a purely combinational decode of s;
//                        clk and reset are present but have no effect.
//                        defined: seg comes from a 7-bit register loaded every rising
//                        edge with the decode of s (1-cycle latency); reset=0 at an edge
//                        blanks the display (7'b1111111) and has priority over s.
module seg_disp (
    input  logic       clk,
    input  logic       reset,
    seg_disp_if.slave  bus
);

    localparam logic [6:0] SegBlank = 7'b1111111;

    logic [6:0] seg_dec;

    // Full 16-entry table, digits 0-9 then A b C d E F.
    always_comb begin
        seg_dec = SegBlank;
        case (bus.s)
            4'h0: seg_dec = 7'b1000000;
            4'h1: seg_dec = 7'b1111001;
            4'h2: seg_dec = 7'b0100100;
            4'h3: seg_dec = 7'b0110000;
            4'h4: seg_dec = 7'b0011001;
            4'h5: seg_dec = 7'b0010010;
            4'h6: seg_dec = 7'b0000010;
            4'h7: seg_dec = 7'b1111000;
            4'h8: seg_dec = 7'b0000000;
            4'h9: seg_dec = 7'b0010000;
            4'hA: seg_dec = 7'b0001000;
            4'hB: seg_dec = 7'b0000011;
            4'hC: seg_dec = 7'b1000110;
            4'hD: seg_dec = 7'b0100001;
            4'hE: seg_dec = 7'b0000110;
            4'hF: seg_dec = 7'b0001110;
            default: seg_dec = SegBlank;
        endcase
    end

`ifdef SEG_DISP_REG_OUT_EN
    logic [6:0] seg_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_q <= SegBlank;
        end else begin
            seg_q <= seg_dec;
        end
    end

    assign bus.seg = seg_q;
`else
    // clk and reset are kept on the port list so both builds share one footprint.
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;

    assign bus.seg = seg_dec;
`endif

endmodule

// File: tb/tb_seg_disp.sv
// tb_seg_disp -- directed self-checking bench for seg_disp (either build).
module tb_seg_disp;

    logic clk = 1'b0;
    logic reset;

    seg_disp_if bus ();

    seg_disp dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] Blank = 7'b1111111;

    // Hand-written reference table: {g,f,e,d,c,b,a}, active-low.
    logic [6:0] exp_tab [16];

    initial begin
        exp_tab[0]  = 7'b1000000;
        exp_tab[1]  = 7'b1111001;
        exp_tab[2]  = 7'b0100100;
        exp_tab[3]  = 7'b0110000;
        exp_tab[4]  = 7'b0011001;
        exp_tab[5]  = 7'b0010010;
        exp_tab[6]  = 7'b0000010;
        exp_tab[7]  = 7'b1111000;
        exp_tab[8]  = 7'b0000000;
        exp_tab[9]  = 7'b0010000;
        exp_tab[10] = 7'b0001000;
        exp_tab[11] = 7'b0000011;
        exp_tab[12] = 7'b1000110;
        exp_tab[13] = 7'b0100001;
        exp_tab[14] = 7'b0000110;
        exp_tab[15] = 7'b0001110;
    end

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: seg=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        bus.s  = 4'h0;
        #1;

`ifdef SEG_DISP_REG_OUT_EN
        // Reset held for two edges with s=3: display dark.
        reset = 1'b0;
        bus.s = 4'h3;
        repeat (2) @(posedge clk);
        #1;
        check("reset_blank", bus.seg, Blank);
        @(negedge clk);
        reset = 1'b1;
        check("release_pre_edge", bus.seg, Blank);
        @(posedge clk);
        #1;
        check("release_digit3", bus.seg, 7'b0110000);

        // Latency: s 1 -> A just after an edge.
        bus.s = 4'h1;
        @(posedge clk);
        #1;
        check("lat_digit1", bus.seg, 7'b1111001);
        bus.s = 4'hA;
        #3;
        check("lat_hold1", bus.seg, 7'b1111001);
        @(posedge clk);
        #1;
        check("lat_digitA", bus.seg, 7'b0001000);

        // Mid-operation reset pulse with E displayed.
        bus.s = 4'hE;
        @(posedge clk);
        #1;
        check("mid_digitE", bus.seg, 7'b0000110);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_blank", bus.seg, Blank);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_restoreE", bus.seg, 7'b0000110);

        // Sweep 0..F then back to 0, one cycle latency each; covers 9->A and F->0.
        for (int i = 0; i < 17; i++) begin
            bus.s = 4'(i % 16);
            #2;
            if (i > 0) check($sformatf("sweep_hold_%0h", (i - 1) % 16), bus.seg, exp_tab[(i - 1) % 16]);
            @(posedge clk);
            #1;
            check($sformatf("sweep_%0h", i % 16), bus.seg, exp_tab[i % 16]);
        end
`else
        check("idle_digit0", bus.seg, 7'b1000000);

        // Exhaustive sweep: apply at rising edge, sample at falling edge.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            bus.s = 4'(i);
            @(negedge clk);
            check($sformatf("sweep_%0h", i), bus.seg, exp_tab[i]);
        end

        // Reset and clock have no effect.
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.s = 4'h8;
        #1;
        check("rst_imm_digit8", bus.seg, 7'b0000000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_hold_pos%0d", k), bus.seg, 7'b0000000);
            @(negedge clk);
            check($sformatf("rst_hold_neg%0d", k), bus.seg, 7'b0000000);
        end
        reset = 1'b1;
        #1;
        check("rst_release_digit8", bus.seg, 7'b0000000);

        // Boundary transitions, zero-cycle latency.
        bus.s = 4'h9;
        #1;
        check("bnd_9", bus.seg, 7'b0010000);
        bus.s = 4'hA;
        #1;
        check("bnd_9_to_A", bus.seg, 7'b0001000);
        bus.s = 4'hF;
        #1;
        check("bnd_F", bus.seg, 7'b0001110);
        bus.s = 4'h0;
        #1;
        check("bnd_F_to_0", bus.seg, 7'b1000000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
